// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  localparam logic [7:0] ERR_DATA = 8'hFF;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter in front of the byte-wide SDRAM controller port.
// A has fixed priority; a streak limit guarantees B a slot under sustained A traffic.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW           = 25,
  parameter int DW           = 8,
  parameter int TIMEOUT      = 255,
  parameter int A_STREAK_MAX = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  input  logic          a_rd,
  input  logic          a_we,
  output logic [DW-1:0] a_dout,
  output logic          a_ack,
  output logic          a_err,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  input  logic          b_rd,
  input  logic          b_we,
  output logic [DW-1:0] b_dout,
  output logic          b_ack,
  output logic          b_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_rd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ready,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(A_STREAK_MAX + 1);

  state_t        state, state_nx;
  port_t         port_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          wr_q;
  logic [TW-1:0] timer;
  logic [SW-1:0] streak;

  logic a_req, b_req, grant_b, strobe, finish;

  always_comb begin
    a_req    = a_rd | a_we;
    b_req    = b_rd | b_we;
    grant_b  = b_req && (!a_req || streak == SW'(A_STREAK_MAX));
    finish   = mem_ready || (timer == TW'(TIMEOUT - 1));
    state_nx = state;
    unique case (state)
      IDLE:    if (a_req || b_req) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (finish) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are decoded from state so an async reset removes them at once.
  assign strobe   = (state == ISSUE) || (state == WAIT);
  assign mem_rd   = strobe && !wr_q;
  assign mem_we   = strobe && wr_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      port_q <= PORT_A;
      addr_q <= '0;
      din_q  <= '0;
      wr_q   <= 1'b0;
      timer  <= '0;
      streak <= '0;
      a_dout <= '0;
      b_dout <= '0;
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      a_err  <= 1'b0;
      b_err  <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      a_err <= 1'b0;
      b_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (a_req || b_req) begin
            port_q <= grant_b ? PORT_B : PORT_A;
            addr_q <= grant_b ? b_addr : a_addr;
            din_q  <= grant_b ? b_din : a_din;
            wr_q   <= grant_b ? b_we : a_we;
          end
          if (grant_b || !b_req)
            streak <= '0;
          else if (a_req && streak != SW'(A_STREAK_MAX))
            streak <= streak + SW'(1);
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + TW'(1);
          // mem_ready takes precedence over a coincident timeout.
          if (finish) begin
            if (port_q == PORT_A) begin
              a_ack <= 1'b1;
              a_err <= !mem_ready;
              if (!wr_q) a_dout <= mem_ready ? mem_dout : DW'(ERR_DATA);
            end else begin
              b_ack <= 1'b1;
              b_err <= !mem_ready;
              if (!wr_q) b_dout <= mem_ready ? mem_dout : DW'(ERR_DATA);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
